branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Parametrised dynamic branch predictor (direct-mapped BTB + saturating counters) for the next-generation pipeline.
//  Sits beside PC/Instruction_Memory in IF: steers next-PC from a same-cycle lookup.
//  Trained from ID/EX branch/jump resolution; replaces flush-on-every-taken-branch with flush-on-mispredict only.
//  Includes an entry-clearing init FSM and saturating performance counters.
// PARAMETERS
//  ADDR_W   32  PC / target width
//  ENTRIES  64  BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
//  TAG_W    8   tag bits, taken from pc[IDX_W+TAG_W+1 : IDX_W+2]
//  CTR_W    2   saturating direction-counter width, >=1
//  CNT_W    16  performance-counter width
// PORTS
//  clk_i          in   1        clock, rising edge
//  rst_i          in   1        synchronous reset, active-low
//  ready_o        out  1        1 = init finished; lookups/updates honoured
//  lu_valid_i     in   1        lookup request (IF stage)
//  lu_pc_i        in   ADDR_W   PC being fetched
//  pred_hit_o     out  1        tag match on valid entry
//  pred_taken_o   out  1        predict taken
//  pred_target_o  out  ADDR_W   predicted target (0 when pred_taken_o=0)
//  upd_valid_i    in   1        resolved branch/jump this cycle
//  upd_pc_i       in   ADDR_W   PC of resolved instruction
//  upd_taken_i    in   1        actual direction
//  upd_target_i   in   ADDR_W   actual target
//  upd_pred_taken_i   in 1      prediction carried down pipeline for this instr
//  upd_pred_target_i  in ADDR_W prediction target carried down pipeline
//  mispredict_o   out  1        update disagrees with carried prediction (drives flush)
//  lookup_cnt_o   out  CNT_W    honoured lookups, saturating
//  mispred_cnt_o  out  CNT_W    mispredicts, saturating
// BEHAVIOUR
//  Index = pc[IDX_W+1:2]; tag as above; pc[1:0] ignored.
//  Entry state: valid, tag, target, ctr[CTR_W-1:0].
//  FSM: INIT -> RUN. rst_i=0 at an edge: state<=INIT, idx<=0, both perf counters<=0.
//   INIT: one entry cleared per cycle (valid<=0, ctr<=0); after entry ENTRIES-1 -> RUN.
//   ready_o=0 for exactly ENTRIES cycles after reset release, then 1.
//   Reset asserted mid-INIT or mid-RUN restarts INIT at index 0.
//  During INIT: pred_* outputs 0, mispredict_o=0, updates and lookups ignored, counters frozen.
//  Lookup (RUN, combinational, 0-cycle latency):
//   pred_hit_o   = lu_valid_i & valid[idx] & (tag==tag[idx])
//   pred_taken_o = pred_hit_o & ctr[idx][CTR_W-1]
//   pred_target_o = pred_taken_o ? target[idx] : 0; all outputs 0 when lu_valid_i=0.
//  Update (RUN, written at clock edge when upd_valid_i=1):
//   hit: ctr +1 if taken (saturate at all-ones), -1 if not (saturate at 0); target<=upd_target_i if taken.
//   miss & taken: allocate/overwrite -> valid=1, new tag, target, ctr = 1<<(CTR_W-1) (weakly taken).
//   miss & not taken: no change.
//  mispredict_o (combinational) = RUN & upd_valid_i &
//   (upd_taken_i != upd_pred_taken_i | (upd_taken_i & upd_target_i != upd_pred_target_i)).
//  Same-cycle lookup and update to same index: lookup returns pre-update state; no bypass.
//  lookup_cnt_o += 1 per RUN cycle with lu_valid_i; mispred_cnt_o += 1 per mispredict_o; hold at 2^CNT_W-1.
//  Reset values: ready_o=0, pred_*=0, mispredict_o=0, counters=0.
// TESTING
//  Reset: rst_i=0 2 cycles then 1 -> ready_o low 64 cycles, high on cycle 65; lookup 0x40 during INIT -> all pred_*=0.
//  Train: 3 updates pc=0x100 taken target=0x200 -> lookup 0x100: hit=1, taken=1, target=0x200; ctr=2'b11.
//  Saturate/decay: from ctr=11, 2 not-taken updates -> ctr=01, pred_taken_o=0 while pred_hit_o=1; further not-taken keeps 00.
//  Alias: train 0x100 taken, then taken update 0x100+4*64 (same index, new tag) -> lookup 0x100 hit=0; new pc hit, ctr=10.
//  Mispredict: upd pc=0x100 taken target=0x300, carried pred taken/0x200 -> mispredict_o=1, mispred_cnt_o 0->1; matching pred -> 0.
//  Same-cycle: lookup & allocating update on 0x180 same cycle -> hit=0 that cycle, hit=1 next; CNT_W=2 counters stop at 3.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating direction counters.
//
// Sits beside the fetch PC. Lookups are combinational and 0-cycle. Resolved branches
// and jumps from the later stages train the table. After reset an init FSM clears
// one entry per cycle. Lookups and updates are ignored until the clear has finished.
//
// Ports
//   clk_i, rst_i             clock (rising edge), synchronous active-low reset
//   ready_o                  init clear finished, table live
//   lu_valid_i, lu_pc_i      fetch-side lookup request
//   pred_hit_o               valid entry with matching tag
//   pred_taken_o             predict taken (counter MSB set on a hit)
//   pred_target_o            predicted target, 0 unless pred_taken_o
//   upd_valid_i ...          resolved instruction: pc, actual direction/target, and the
//   upd_pred_*_i             prediction that was carried down the pipe for it
//   mispredict_o             resolution disagrees with the carried prediction
//   lookup_cnt_o             honoured lookups, saturating
//   mispred_cnt_o            mispredicts, saturating

module branch_predictor #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              ready_o,
    input  logic              lu_valid_i,
    input  logic [ADDR_W-1:0] lu_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [CNT_W-1:0]  lookup_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    localparam logic [CTR_W-1:0] CtrOne  = CTR_W'(1);
    localparam logic [CTR_W-1:0] CtrWeak = CtrOne << (CTR_W - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Table storage. Cleared by the init FSM rather than by reset.
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic              run;
    logic [IDX_W-1:0]  lu_idx, upd_idx;
    logic [TAG_W-1:0]  lu_tag, upd_tag;
    logic              upd_hit;
    logic              ent_we;
    logic [CTR_W-1:0]  ent_ctr_d;
    logic [ADDR_W-1:0] ent_target_d;

    // Only the index/tag fields of the PCs are decoded; the rest is don't-care.
    logic unused_pc;
    assign unused_pc = ^{lu_pc_i, upd_pc_i};

    assign run     = (state_q == StRun);
    assign ready_o = run;

    assign lu_idx  = lu_pc_i[IDX_W+1:2];
    assign lu_tag  = lu_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the pre-update table; a same-cycle update is not bypassed.
    always_comb begin
        pred_hit_o    = 1'b0;
        pred_taken_o  = 1'b0;
        pred_target_o = '0;
        if (run && lu_valid_i && valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag)) begin
            pred_hit_o = 1'b1;
        end
        pred_taken_o = pred_hit_o & ctr_q[lu_idx][CTR_W-1];
        if (pred_taken_o) begin
            pred_target_o = target_q[lu_idx];
        end
    end

    // The carried target only matters when the branch was actually taken.
    assign mispredict_o = run && upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    // Update path: train on a hit, allocate only on a taken miss.
    always_comb begin
        upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ent_we       = run && upd_valid_i && (upd_hit || upd_taken_i);
        ent_ctr_d    = ctr_q[upd_idx];
        ent_target_d = target_q[upd_idx];
        if (upd_taken_i) begin
            ent_target_d = upd_target_i;
        end
        if (!upd_hit) begin
            ent_ctr_d = CtrWeak;
        end else if (upd_taken_i) begin
            if (ctr_q[upd_idx] != '1) begin
                ent_ctr_d = ctr_q[upd_idx] + CtrOne;
            end
        end else begin
            if (ctr_q[upd_idx] != '0) begin
                ent_ctr_d = ctr_q[upd_idx] - CtrOne;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        unique case (state_q)
            StInit: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IdxLast) begin
                    state_d    = StRun;
                    init_idx_d = '0;
                end
            end
            StRun: begin
                if (lu_valid_i && (lookup_cnt_q != '1)) begin
                    lookup_cnt_d = lookup_cnt_q + CntOne;
                end
                if (mispredict_o && (mispred_cnt_q != '1)) begin
                    mispred_cnt_d = mispred_cnt_q + CntOne;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= StInit;
            init_idx_q    <= '0;
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (state_q == StInit) begin
                valid_q[init_idx_q] <= 1'b0;
                ctr_q[init_idx_q]   <= '0;
            end else if (ent_we) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= ent_target_d;
                ctr_q[upd_idx]    <= ent_ctr_d;
            end
        end
    end

    assign lookup_cnt_o  = lookup_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ready_o;
    logic        lu_valid_i;
    logic [31:0] lu_pc_i;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic [31:0] upd_pred_target_i;
    logic        mispredict_o;
    logic [CNT_W-1:0] lookup_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    branch_predictor #(
        .ADDR_W (32),
        .ENTRIES(64),
        .TAG_W  (8),
        .CTR_W  (2),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .ready_o          (ready_o),
        .lu_valid_i       (lu_valid_i),
        .lu_pc_i          (lu_pc_i),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .upd_pred_target_i(upd_pred_target_i),
        .mispredict_o     (mispredict_o),
        .lookup_cnt_o     (lookup_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        lu_v;
        logic [31:0] lu_pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_tgt;
        logic        e_mp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int exp_lu = 0;
    int exp_mp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic luv, input logic [31:0] lpc,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic upt,
                                input logic [31:0] uptgt, input logic eh, input logic et,
                                input logic [31:0] etgt, input logic emp);
        vec_t v;
        v.name = nm; v.lu_v = luv; v.lu_pc = lpc; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.upt = upt; v.uptgt = uptgt; v.e_hit = eh; v.e_taken = et;
        v.e_tgt = etgt; v.e_mp = emp;
        return v;
    endfunction

    task automatic idle_inputs();
        lu_valid_i = 0; lu_pc_i = 0; upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0;
        upd_target_i = 0; upd_pred_taken_i = 0; upd_pred_target_i = 0;
    endtask

    // Drive one cycle of stimulus after a rising edge, compare before the next one.
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        lu_valid_i = v.lu_v; lu_pc_i = v.lu_pc; upd_valid_i = v.uv; upd_pc_i = v.upc;
        upd_taken_i = v.ut; upd_target_i = v.utgt; upd_pred_taken_i = v.upt;
        upd_pred_target_i = v.uptgt;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".ready"}, 32'(ready_o), 32'd1);
        chk({e.name, ".hit"}, 32'(pred_hit_o), 32'(e.e_hit));
        chk({e.name, ".taken"}, 32'(pred_taken_o), 32'(e.e_taken));
        chk({e.name, ".target"}, pred_target_o, e.e_tgt);
        chk({e.name, ".mispredict"}, 32'(mispredict_o), 32'(e.e_mp));
        chk({e.name, ".lookup_cnt"}, 32'(lookup_cnt_o), 32'(exp_lu));
        chk({e.name, ".mispred_cnt"}, 32'(mispred_cnt_o), 32'(exp_mp));
        if (e.lu_v && exp_lu < CNT_MAX) exp_lu++;
        if (e.e_mp && exp_mp < CNT_MAX) exp_mp++;
    endtask

    // Hold reset for 'hold' edges, release, and time the init clear while hammering
    // the lookup/update ports, which must stay inert.
    task automatic do_reset(input int hold);
        int  n;
        bit  noisy;
        @(posedge clk);
        #1 rst_i = 0;
        idle_inputs();
        repeat (hold) @(posedge clk);
        #1;
        chk("reset.ready_low", 32'(ready_o), 32'd0);
        rst_i = 1;
        lu_valid_i = 1; lu_pc_i = 32'h40;
        upd_valid_i = 1; upd_pc_i = 32'h40; upd_taken_i = 1; upd_target_i = 32'h80;
        upd_pred_taken_i = 0; upd_pred_target_i = 0;
        n = 0;
        noisy = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            n++;
            if (pred_hit_o || pred_taken_o || pred_target_o != 0 || mispredict_o ||
                lookup_cnt_o != 0 || mispred_cnt_o != 0) noisy = 1;
            @(negedge clk);
        end
        idle_inputs();
        chk("init.low_cycles", 32'(n), 32'd64);
        chk("init.outputs_quiet", 32'(noisy), 32'd0);
        chk("init.ready_high", 32'(ready_o), 32'd1);
        chk("init.lookup_cnt", 32'(lookup_cnt_o), 32'd0);
        chk("init.mispred_cnt", 32'(mispred_cnt_o), 32'd0);
        exp_lu = 0;
        exp_mp = 0;
    endtask

    initial begin
        rst_i = 0;
        idle_inputs();

        //        name        luv lu_pc    uv upc      ut utgt     upt uptgt    hit tk tgt      mp
        tbl.push_back(mk("cold_miss", 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0));
        tbl.push_back(mk("alloc",     0, 32'h0,   1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 0, 32'h0,   1));
        tbl.push_back(mk("train1",    1, 32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 1, 32'h200, 0));
        tbl.push_back(mk("train2",    1, 32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 1, 1, 32'h200, 0));
        tbl.push_back(mk("strong",    1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0));
        tbl.push_back(mk("decay1",    1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200, 1, 1, 32'h200, 1));
        tbl.push_back(mk("decay2",    1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0));
        tbl.push_back(mk("weak_nt",   1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0));
        tbl.push_back(mk("decay3",    1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0));
        tbl.push_back(mk("floor",     1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0));
        tbl.push_back(mk("rise1",     1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   1, 0, 32'h0,   1));
        tbl.push_back(mk("floor_chk", 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0));
        tbl.push_back(mk("retarget",  1, 32'h100, 1, 32'h100, 1, 32'h240, 0, 32'h0,   1, 0, 32'h0,   1));
        tbl.push_back(mk("new_tgt",   1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 1, 32'h240, 0));
        tbl.push_back(mk("alias_upd", 1, 32'h100, 1, 32'h200, 1, 32'h300, 0, 32'h0,   1, 1, 32'h240, 1));
        tbl.push_back(mk("alias_old", 1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0));
        tbl.push_back(mk("alias_new", 1, 32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 1, 32'h300, 0));
        tbl.push_back(mk("alias_dec", 1, 32'h200, 1, 32'h200, 0, 32'h0,   1, 32'h300, 1, 1, 32'h300, 1));
        tbl.push_back(mk("alias_wk",  1, 32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0));
        tbl.push_back(mk("low_bits",  1, 32'h202, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0));
        tbl.push_back(mk("mp_target", 0, 32'h0,   1, 32'h100, 1, 32'h300, 1, 32'h200, 0, 0, 32'h0,   1));
        tbl.push_back(mk("mp_match",  1, 32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h300, 1, 1, 32'h300, 0));
        tbl.push_back(mk("nt_any_tgt",1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 32'h123, 1, 1, 32'h300, 0));
        tbl.push_back(mk("miss_nt",   1, 32'h40,  1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0));
        tbl.push_back(mk("miss_nt2",  1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0));
        tbl.push_back(mk("same_cyc",  1, 32'h180, 1, 32'h180, 1, 32'h1c0, 0, 32'h0,   0, 0, 32'h0,   1));
        tbl.push_back(mk("same_nxt",  1, 32'h180, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 1, 32'h1c0, 0));
        tbl.push_back(mk("no_valid",  0, 32'h180, 0, 32'h100, 1, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0));

        do_reset(2);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        chk("sat.lookup_cnt", 32'(lookup_cnt_o), 32'(CNT_MAX));
        chk("sat.mispred_cnt", 32'(mispred_cnt_o), 32'(CNT_MAX));

        // Reset from RUN wipes the table.
        do_reset(1);
        apply(mk("rst_run_0x100", 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));
        apply(mk("rst_run_0x180", 1, 32'h180, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));

        // Reset part-way through INIT restarts the clear from index 0.
        @(posedge clk);
        #1 rst_i = 0;
        @(posedge clk);
        #1 rst_i = 1;
        repeat (10) @(posedge clk);
        do_reset(1);
        apply(mk("rst_init_lu", 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
